// File: rtl/shift_pkg.sv
// Shared types and limits for the multi-cycle shift sequencer.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic       SHIFT_LEFT    = 1'b1;
  localparam logic       SHIFT_LOGICAL = 1'b1;
  localparam logic [3:0] MAX_LEFT_AMT  = 4'd14;
  localparam logic [3:0] MAX_RIGHT_AMT = 4'd15;

  // The down-counter must hold the largest legal amount in either direction.
  localparam int CNT_W = $clog2(int'(MAX_RIGHT_AMT) + 1);

  // Only left-by-15 is rejected; every 4-bit right amount is legal.
  function automatic logic amt_illegal(input logic dir, input logic [3:0] amt);
    return (dir == SHIFT_LEFT) && (amt > MAX_LEFT_AMT);
  endfunction

endpackage

// File: rtl/shift_step.sv
// One-position shift used once per SHIFT cycle by the sequencer.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_src,
  input  logic             i_dir,
  input  logic             i_type,
  output logic [WIDTH-1:0] o_out
);

  // Left shifts ignore type; right shifts fill the MSB with 0 or the sign.
  always_comb begin
    o_out = i_src;
    if (i_dir == SHIFT_LEFT) begin
      o_out = {i_src[WIDTH-2:0], 1'b0};
    end else if (i_type == SHIFT_LOGICAL) begin
      o_out = {1'b0, i_src[WIDTH-1:1]};
    end else begin
      o_out = {i_src[WIDTH-1], i_src[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: one single-bit shift per clock, done pulse at end.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// SHIFT | applying one shift step per cycle, counter running down
// DONE  | result valid, one-cycle done pulse; may accept a new start
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src,
  input  logic             shiftDirection,
  input  logic             shiftType,
  input  logic [3:0]       shiftAmt,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] result
);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic               r_dir;
  logic               r_type;
  logic               r_illegal;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   w_step;
  logic               w_accept;
  logic               w_req_illegal;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_src  (r_result),
    .i_dir  (r_dir),
    .i_type (r_type),
    .o_out  (w_step)
  );

  // Next-state and status decode; busy/done come straight from the state register.
  always_comb begin
    w_state_next  = r_state;
    busy          = 1'b0;
    done          = 1'b0;
    w_accept      = start && ((r_state == IDLE) || (r_state == DONE));
    w_req_illegal = amt_illegal(shiftDirection, shiftAmt);
    case (r_state)
      IDLE, DONE: begin
        done = (r_state == DONE);
        if (w_accept) begin
          w_state_next = ((shiftAmt == '0) || w_req_illegal) ? DONE : SHIFT;
        end else begin
          w_state_next = IDLE;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (r_count == CNT_W'(1)) w_state_next = DONE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Operand capture on accept, then one step and one count per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_result  <= '0;
      r_count   <= '0;
      r_dir     <= 1'b0;
      r_type    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_result  <= src;
      r_count   <= shiftAmt;
      r_dir     <= shiftDirection;
      r_type    <= shiftType;
      r_illegal <= w_req_illegal;
    end else if (r_state == SHIFT) begin
      r_result  <= w_step;
      r_count   <= r_count - 1'b1;
    end
  end

  assign illegal = r_illegal;
  assign result  = r_result;

endmodule
